tdc_therm_decoder: RTL and testbench
====================================

Name: tdc_therm_decoder

Overview:
- Downstream consumer of the 32-bit UP/DWN thermometer codes produced by the TDC phase-detector stage.
- Samples both codes on fb_clk and converts each to a binary length. Tolerates bubbles.
- Forms a signed phase error, saturates it, and drives a lock detector for the ADPLL digital loop filter.
- 3-stage pipeline; all state clocked by fb_clk.

Parameters:
- THERM_W, 32, width of each thermometer input code
- CNT_W, 6, width of decoded length (0..THERM_W)
- ERR_W, 7, width of signed phase error (two's complement)
- ERR_SAT, 31, magnitude clamp applied to phase_err
- LOCK_THRESH, 2, max |phase_err| counted as "in lock"
- LOCK_COUNT, 8, consecutive in-lock samples required to assert lock

Ports:
- fb_clk  input  1  feedback clock; all flops on rising edge
- reset_trig  input  1  asynchronous, active-high reset
- en  input  1  sample enable; when 0, no new sample enters the pipeline
- up_error  input  THERM_W  UP thermometer code (ones fill from bit 0 upward)
- dwn_error  input  THERM_W  DWN thermometer code (same format)
- phase_err  output  ERR_W  signed, saturated (up_len - dwn_len)
- err_valid  output  1  1-cycle pulse; phase_err updated this cycle
- bubble_flag  output  1  a bubble was detected in the sample now presented
- lock  output  1  loop lock indication

Behaviour:
Reset:
- reset_trig is asynchronous, active-high.
- All pipeline registers, valid bits, lock counter and outputs clear to 0.
- Output reset values: phase_err=0, err_valid=0, bubble_flag=0, lock=0.
- Reset mid-pipeline discards all in-flight samples. No err_valid is emitted for them.

Stage S1 (capture):
- On a fb_clk edge with en=1, register up_error, dwn_error and v1=1.
- With en=0, set v1=0 and hold the data registers.

Stage S2 (decode), applied to each captured code separately:
- len = index of the first 0 scanned from bit 0, or THERM_W if the code is all ones. Range 0..32, CNT_W bits.
- bubble = 1 if any bit at or above that first-0 index is 1.
- Bubbled bits are ignored, so len is the contiguous-ones run from the LSB.
- v2 <= v1.
- b2 <= bubble_up OR bubble_dwn.

Stage S3 (error and lock):
- diff = zero-extend(up_len) - zero-extend(dwn_len), computed at ERR_W+1 bits. Range -32..+32.
- Clamp to [-ERR_SAT, +ERR_SAT].
- Register the result into phase_err only when v2=1; otherwise hold the previous phase_err.
- err_valid <= v2.
- bubble_flag <= b2 when v2=1, else 0.

Latency:
- A sample captured at edge N appears on phase_err/err_valid at edge N+2 (S1 at N, S2 at N+1, S3 at N+2).
- With en held at 1, throughput is one sample per cycle.

Lock detector (updates only on v2=1 cycles):
- in_lock = (|clamped diff| <= LOCK_THRESH) AND (b2 = 0).
- If in_lock: lock_cnt increments, saturating at LOCK_COUNT. lock=1 once lock_cnt reaches LOCK_COUNT.
- If not in_lock: lock_cnt=0 and lock=0, in the same edge as the failing sample's phase_err.
- Cycles with v2=0 leave lock_cnt and lock unchanged.

Boundary cases:
- Both codes all zero: diff=0, in_lock. (Idle PD with start not yet set reads as zero error.)
- Both codes all ones: diff=0.
- One code all ones, other all zero: diff=±32, clamped to ±31.
- en toggling creates gaps in err_valid, with no spurious pulses.

Test Plan:
1. Clean codes:
   - Reset, then en=1, up=0x0000_00FF, dwn=0x0000_000F.
   - Expect err_valid 2 edges after capture; phase_err=+4; bubble_flag=0.
2. Saturation:
   - up=0xFFFF_FFFF, dwn=0 -> phase_err=+31.
   - up=0, dwn=0xFFFF_FFFF -> phase_err=-31.
   - Back-to-back cycles give consecutive err_valid pulses.
3. Bubble:
   - up=0x0000_0F7F (run 7, bubble above), dwn=0x0000_0007.
   - Expect phase_err=+4, bubble_flag=1.
   - lock_cnt cleared; lock=0 even if previously locked.
4. Lock acquire and loss:
   - 8 consecutive samples with up=0x7, dwn=0x1F (err=-2) -> lock=1 on the 8th err_valid.
   - Then one sample with err=+3 -> lock=0 on that sample's err_valid edge.
5. Enable gaps:
   - Alternate en=1/0 with varying codes.
   - err_valid pulses only for the enabled samples, each 2 edges later.
   - phase_err holds between pulses; lock_cnt does not advance on gaps.
6. Reset mid-operation:
   - Assert reset_trig asynchronously between fb_clk edges while 2 samples are in flight.
   - All outputs go to 0 immediately; no err_valid afterwards.
   - Lock reacquisition requires 8 fresh in-lock samples.

Source files
------------

// File: rtl/tdc_therm_decoder.sv
// tdc_therm_decoder: bubble-tolerant UP/DWN thermometer decode into a saturated signed
// phase error with lock detection, 3-stage pipeline on fb_clk.
module tdc_therm_decoder #(
    parameter int THERM_W     = 32,
    parameter int CNT_W       = 6,
    parameter int ERR_W       = 7,
    parameter int ERR_SAT     = 31,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_COUNT  = 8
) (
    input  logic               fb_clk,
    input  logic               reset_trig,
    input  logic               en,
    input  logic [THERM_W-1:0] up_error,
    input  logic [THERM_W-1:0] dwn_error,
    output logic [ERR_W-1:0]   phase_err,
    output logic               err_valid,
    output logic               bubble_flag,
    output logic               lock
);
    localparam int LC_W = $clog2(LOCK_COUNT + 1);
    localparam logic signed [ERR_W:0] SAT = (ERR_W+1)'(ERR_SAT);
    localparam logic [ERR_W:0] THR = (ERR_W+1)'(LOCK_THRESH);
    logic [THERM_W-1:0]    up_q, dwn_q;
    logic                  v1_q, v2_q, b2_q, b2_d;
    logic [CNT_W-1:0]      up_len_q, dwn_len_q, up_len_d, dwn_len_d;
    logic signed [ERR_W:0] diff, clamp;
    logic [ERR_W:0]        mag;
    logic                  in_lock;
    logic [LC_W-1:0]       cnt_q, cnt_d;
    logic [ERR_W-1:0]      phase_err_q;
    logic                  err_valid_q, bubble_q, lock_q;
    // c & ~(c+1) keeps only the contiguous ones run from bit 0; c & (c+1) is nonzero iff a bubble exists
    always_comb begin
        up_len_d  = CNT_W'($countones(up_q & ~(up_q + THERM_W'(1))));
        dwn_len_d = CNT_W'($countones(dwn_q & ~(dwn_q + THERM_W'(1))));
        b2_d      = (|(up_q & (up_q + THERM_W'(1)))) | (|(dwn_q & (dwn_q + THERM_W'(1))));
        diff      = $signed((ERR_W+1)'(up_len_q)) - $signed((ERR_W+1)'(dwn_len_q));
        clamp     = (diff > SAT) ? SAT : ((diff < -SAT) ? -SAT : diff);
        mag       = clamp[ERR_W] ? $unsigned(-clamp) : $unsigned(clamp);
        in_lock   = (mag <= THR) && !b2_q;
        cnt_d     = !in_lock ? '0 : ((cnt_q == LC_W'(LOCK_COUNT)) ? cnt_q : cnt_q + LC_W'(1));
    end
    always_ff @(posedge fb_clk or posedge reset_trig) begin
        if (reset_trig) begin
            up_q        <= '0;
            dwn_q       <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            b2_q        <= 1'b0;
            up_len_q    <= '0;
            dwn_len_q   <= '0;
            phase_err_q <= '0;
            err_valid_q <= 1'b0;
            bubble_q    <= 1'b0;
            cnt_q       <= '0;
            lock_q      <= 1'b0;
        end else begin
            v1_q <= en;
            if (en) begin
                up_q  <= up_error;
                dwn_q <= dwn_error;
            end
            v2_q        <= v1_q;
            up_len_q    <= up_len_d;
            dwn_len_q   <= dwn_len_d;
            b2_q        <= b2_d;
            err_valid_q <= v2_q;
            bubble_q    <= v2_q & b2_q;
            if (v2_q) begin
                phase_err_q <= clamp[ERR_W-1:0];
                cnt_q       <= cnt_d;
                lock_q      <= (cnt_d == LC_W'(LOCK_COUNT));
            end
        end
    end
    assign phase_err   = phase_err_q;
    assign err_valid   = err_valid_q;
    assign bubble_flag = bubble_q;
    assign lock        = lock_q;
endmodule

// File: tb/tb_tdc_therm_decoder.sv
// tb_tdc_therm_decoder: directed and randomized checks of tdc_therm_decoder against a
// sample-level reference model (contiguous-run lengths, clamp, lock counting).
module tb_tdc_therm_decoder;
    logic        fb_clk = 1'b0;
    logic        reset_trig = 1'b1;
    logic        en = 1'b0;
    logic [31:0] up_error = '0, dwn_error = '0;
    logic [6:0]  phase_err;
    logic        err_valid, bubble_flag, lock;
    int          n_assert = 0, n_fail = 0;
    bit          pv[2];
    logic [31:0] pu[2], pd[2];
    int          exp_pe, cnt;
    bit          exp_ev, exp_bf, exp_lk;

    tdc_therm_decoder dut (
        .fb_clk(fb_clk), .reset_trig(reset_trig), .en(en),
        .up_error(up_error), .dwn_error(dwn_error),
        .phase_err(phase_err), .err_valid(err_valid),
        .bubble_flag(bubble_flag), .lock(lock)
    );

    always #5 fb_clk = ~fb_clk;

    function automatic int tlen(input logic [31:0] c);
        int n = 0;
        while (n < 32 && c[n]) n++;
        return n;
    endfunction

    function automatic bit bub(input logic [31:0] c);
        for (int i = tlen(c) + 1; i < 32; i++) if (c[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mk(input int l, input bit b);
        logic [31:0] c = (l >= 32) ? 32'hFFFF_FFFF : ((32'h1 << l) - 32'h1);
        if (b && l < 31) c = c | ($urandom << (l + 1));
        return c;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        pv[0] = 0; pv[1] = 0;
        exp_pe = 0; cnt = 0; exp_ev = 0; exp_bf = 0; exp_lk = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_valid"}, 32'(err_valid), 32'(exp_ev));
        chk({tag, "_perr"}, $signed(phase_err), exp_pe);
        chk({tag, "_bubble"}, 32'(bubble_flag), 32'(exp_bf));
        chk({tag, "_lock"}, 32'(lock), 32'(exp_lk));
    endtask

    task automatic step(input string tag, input bit e, input logic [31:0] u, input logic [31:0] d);
        int df;
        bit bb;
        en = e; up_error = u; dwn_error = d;
        @(posedge fb_clk);
        #1;
        exp_ev = pv[1];
        exp_bf = 0;
        if (pv[1]) begin
            df = tlen(pu[1]) - tlen(pd[1]);
            df = (df > 31) ? 31 : ((df < -31) ? -31 : df);
            bb = bub(pu[1]) || bub(pd[1]);
            exp_pe = df;
            exp_bf = bb;
            if ((df < 0 ? -df : df) <= 2 && !bb) cnt = (cnt < 8) ? cnt + 1 : 8;
            else cnt = 0;
            exp_lk = (cnt == 8);
        end
        pv[1] = pv[0]; pu[1] = pu[0]; pd[1] = pd[0];
        pv[0] = e; pu[0] = u; pd[0] = d;
        check_outs(tag);
    endtask

    initial begin
        model_clear();
        #12;
        check_outs("reset");
        #8 reset_trig = 1'b0;

        step("clean", 1, 32'h0000_00FF, 32'h0000_000F);
        step("clean", 0, 0, 0);
        step("clean", 0, 0, 0);
        chk("clean_plus4", $signed(phase_err), 4);

        step("sat", 1, 32'hFFFF_FFFF, 32'h0);
        step("sat", 1, 32'h0, 32'hFFFF_FFFF);
        step("sat", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step("sat", 1, 32'h0, 32'h0);
        step("sat", 0, 0, 0);
        step("sat", 0, 0, 0);

        for (int i = 0; i < 8; i++) step("acq", 1, 32'h7, 32'h1F);
        step("acq", 0, 0, 0);
        step("acq", 0, 0, 0);
        chk("acq_locked", 32'(lock), 1);
        step("bubble", 1, 32'h0000_0F7F, 32'h0000_0007);
        step("bubble", 0, 0, 0);
        step("bubble", 0, 0, 0);
        chk("bubble_unlock", 32'(lock), 0);

        for (int i = 0; i < 8; i++) step("relock", 1, 32'h7, 32'h1F);
        step("loss", 1, 32'h3F, 32'h7);
        step("loss", 0, 0, 0);
        step("loss", 0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            int ul = $urandom_range(0, 32);
            int dl = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 32) : (ul + $urandom_range(0, 4) > 34 ? 32 : (ul + $urandom_range(0, 4) < 2 ? 0 : ul + $urandom_range(0, 4) - 2));
            if (dl > 32) dl = 32;
            step("rand", 1'($urandom_range(0, 1)), mk(ul, $urandom_range(0, 5) == 0), mk(dl, $urandom_range(0, 5) == 0));
        end

        for (int i = 0; i < 10; i++) step("prerst", 1, 32'h3, 32'h7);
        step("prerst", 1, 32'h1F, 32'h7F);
        step("prerst", 1, 32'h1F, 32'h7F);
        #2 reset_trig = 1'b1;
        #1;
        model_clear();
        check_outs("midrst");
        @(posedge fb_clk);
        en = 1'b0;
        @(negedge fb_clk);
        reset_trig = 1'b0;
        for (int i = 0; i < 3; i++) step("postrst", 0, 32'hFF, 32'h0);
        for (int i = 0; i < 8; i++) step("reacq", 1, 32'h1, 32'h0);
        step("reacq", 0, 0, 0);
        chk("reacq_not_yet", 32'(lock), 0);
        step("reacq", 0, 0, 0);
        chk("reacq_locked", 32'(lock), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
